memory_stage: RTL and testbench
===============================

// Module: memory_stage
// PURPOSE
//   Memory-access stage fed directly by the execute->memory pipeline register. Runs the
//   one-hot load/store op on a req/gnt/rvalid data bus and lane-aligns store data/strobes.
//   Sign/zero-extends load data and forwards valM to the writeback register.
//   Stalls the front of the pipe (incl. the feeding register) until the access completes.
// PARAMETERS
//   TIMEOUT_CYCLES  255  max cycles in REQ+WAIT before bus error; 0 = no timeout; max 65535
// PORTS
//   clk                 in   1   clock
//   rst                 in   1   reset (synchronous, active-high)
//   regM_i_commit       in   1   instruction in memory stage is valid
//   regM_i_valE         in   32  ALU result (pass-through for non-memory ops)
//   regM_i_mem_addr     in   32  byte address of access
//   regM_i_valB         in   32  store data (rs2)
//   regM_i_ls_info      in   8   one-hot: [0]lb [1]lh [2]lw [3]lbu [4]lhu [5]sb [6]sh [7]sw
//   dmem_req_o          out  1   bus request, held until dmem_gnt_i
//   dmem_we_o           out  1   1 = store
//   dmem_addr_o         out  32  {regM_i_mem_addr[31:2],2'b00}
//   dmem_wdata_o        out  32  lane-replicated store data
//   dmem_wstrb_o        out  4   byte strobes (0 for loads)
//   dmem_gnt_i          in   1   request accepted this cycle
//   dmem_rvalid_i       in   1   load data valid this cycle
//   dmem_rdata_i        in   32  load word
//   memory_o_valM       out  32  result to writeback
//   memory_o_stall      out  1   hold upstream registers this cycle
//   memory_o_done       out  1   memory op completes this cycle (1-cycle pulse)
//   memory_o_bus_err    out  1   access ended by timeout (valid with done)
//   memory_o_misalign   out  1   misaligned access (valid with done; 0 without macro)
// BEHAVIOUR
//   - mem op = regM_i_commit & |regM_i_ls_info. FSM states IDLE, REQ, WAIT, DONE.
//   - IDLE: mem op -> stall=1, go REQ (or DONE if misaligned with macro). Else stall=0.
//   - REQ: dmem_req_o=1 (registered, held stable); gnt & store -> DONE; gnt & load -> WAIT,
//     or DONE if rvalid in same cycle (data captured). rvalid without gnt ignored.
//   - WAIT: rvalid -> capture formatted data into load_q, go DONE.
//   - DONE: stall=0, done=1, then IDLE; upstream advances at the end of this cycle.
//   - stall=1 in REQ, WAIT and in IDLE on a mem op; stall=0 in DONE.
//   - Min latency (cycles in stage): store 3, load 3 if gnt+rvalid coincide, else 4.
//   - valM = load_q in DONE for loads; 0 on load error/misalign; else regM_i_valE (comb).
//   - Store: sb wstrb=4'b0001<<a[1:0], wdata={4{B[7:0]}}; sh wstrb=4'b0011<<{a[1],1'b0},
//     wdata={2{B[15:0]}}; sw wstrb=4'hF, wdata=B.
//   - Load: d = rdata>>{a[1:0],3'b0}; lb/lh sign-extend, lbu/lhu zero-extend, lw d.
//   - Timeout: 16-bit counter cleared on entering REQ, increments in REQ/WAIT; reaching
//     TIMEOUT_CYCLES -> DONE with bus_err=1. Late rvalid after that in IDLE is ignored.
//   - Reset values: state IDLE, dmem_req_o 0, dmem_we_o 0, wstrb 0, load_q 0, counter 0;
//     done/bus_err/misalign/stall 0. Reset mid-op abandons access; req drops next edge.
//   - Bus outputs (addr/wdata/we/wstrb) registered on IDLE->REQ, stable until gnt.
// CONFIGURATION
//   MEM_MISALIGN_TRAP_EN defined: lh/lhu/sh with a[0]=1 or lw/sw with a[1:0]!=0 issue
//     no bus request; IDLE->DONE with misalign=1, valM=0, no memory write.
//   Undefined: memory_o_misalign tied 0; offset forced to natural alignment (a[0]
//     cleared for half, a[1:0] cleared for word) and access proceeds normally.
// TESTING
//   1. sw a=0x100 B=0xDEADBEEF, gnt next cycle -> addr 0x100, wstrb F, wdata DEADBEEF; 3 cyc.
//   2. lb a=0x103, rdata=0x80FF_0000, gnt+rvalid same cycle -> valM=0xFFFFFF80, done@cyc 3.
//   3. lhu a=0x202, gnt then rvalid 2 cycles later, rdata=0xBEEF1234 -> valM=0x0000BEEF.
//   4. sb a=0x101 B=0x000000AB -> wstrb 0010, wdata 0xABABABAB; non-mem op valE=5 -> valM=5.
//   5. TIMEOUT_CYCLES=4, gnt never -> done+bus_err after 4 REQ cycles; rst in WAIT -> IDLE.
//   6. Macro on: lw a=0x102 -> no dmem_req_o, done+misalign next cycle, valM=0.

Source files
------------

// File: rtl/memory_stage_if.sv
// memory_stage_if
//   Data-bus bundle between the memory stage and data memory. The bus uses
//   req/gnt for the command phase and rvalid/rdata for load data.
//   The master modport is the memory stage. The slave modport is the memory.
interface memory_stage_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, wdata, wstrb,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata, wstrb,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/memory_stage.sv
// memory_stage
//   Memory-access stage fed by the execute->memory pipeline register.
//   - Sequences one load or store on a req/gnt/rvalid bus.
//   - Lane-aligns store data and strobes, and formats load data with sign or zero extension.
//   - Holds the front of the pipe until the access completes.
//   Optional feature: define MEM_MISALIGN_TRAP_EN to turn misaligned
//   half/word accesses into a misalign completion with no bus request.
//   When the macro is undefined, the byte offset is forced to natural alignment.
module memory_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           regM_i_commit,
    input  logic [31:0]    regM_i_valE,
    input  logic [31:0]    regM_i_mem_addr,
    input  logic [31:0]    regM_i_valB,
    input  logic [7:0]     regM_i_ls_info,
    memory_stage_if.master dmem,
    output logic [31:0]    memory_o_valM,
    output logic           memory_o_stall,
    output logic           memory_o_done,
    output logic           memory_o_bus_err,
    output logic           memory_o_misalign
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // The last counter value allowed before the access is abandoned.
    // A value of 0 disables the timeout.
    localparam int unsigned TO_LAST_I = (TIMEOUT_CYCLES == 32'd0) ? 32'd0 : (TIMEOUT_CYCLES - 32'd1);
    localparam logic [15:0] TO_LAST   = TO_LAST_I[15:0];
    localparam logic        TO_EN     = (TIMEOUT_CYCLES != 32'd0);

    // Byte strobes for a store. The one-hot op bits are [5]sb [6]sh [7]sw.
    function automatic logic [3:0] lane_strb(input logic [7:0] ls, input logic [1:0] off);
        logic [3:0] strb;
        if (ls[5]) begin
            strb = 4'b0001 << off;
        end else if (ls[6]) begin
            strb = 4'b0011 << off;
        end else if (ls[7]) begin
            strb = 4'b1111;
        end else begin
            strb = 4'b0000;
        end
        return strb;
    endfunction

    // Store data replicated across every lane the access could land in.
    function automatic logic [31:0] lane_wdata(input logic [7:0] ls, input logic [31:0] b);
        logic [31:0] data;
        if (ls[5]) begin
            data = {4{b[7:0]}};
        end else if (ls[6]) begin
            data = {2{b[15:0]}};
        end else if (ls[7]) begin
            data = b;
        end else begin
            data = 32'h0000_0000;
        end
        return data;
    endfunction

    // Shift the addressed lane down, then sign- or zero-extend it.
    // The one-hot op bits are [0]lb [1]lh [2]lw [3]lbu [4]lhu.
    function automatic logic [31:0] load_format(input logic [4:0] ls, input logic [1:0] off,
                                                input logic [31:0] rdata);
        logic [31:0] d;
        logic [31:0] res;
        d = rdata >> {off, 3'b000};
        if (ls[0]) begin
            res = {{24{d[7]}}, d[7:0]};
        end else if (ls[1]) begin
            res = {{16{d[15]}}, d[15:0]};
        end else if (ls[2]) begin
            res = d;
        end else if (ls[3]) begin
            res = {24'h00_0000, d[7:0]};
        end else if (ls[4]) begin
            res = {16'h0000, d[15:0]};
        end else begin
            res = 32'h0000_0000;
        end
        return res;
    endfunction

    state_t      state_r;
    state_t      state_s;

    logic        req_r;
    logic        we_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic [3:0]  wstrb_r;
    logic [4:0]  ls_r;
    logic [1:0]  off_r;
    logic [31:0] load_r;
    logic [15:0] cnt_r;
    logic        err_r;
    logic        mis_r;

    logic        mem_op_s;
    logic        is_store_s;
    logic        is_half_s;
    logic        is_word_s;
    logic [1:0]  off_s;
    logic        trap_s;
    logic        to_hit_s;
    logic        enter_req_s;
    logic        capture_s;
    logic        err_set_s;
    logic        mis_set_s;
    logic        stall_s;
    logic        done_s;
    logic [31:0] valm_s;

    assign mem_op_s   = regM_i_commit & (|regM_i_ls_info);
    assign is_store_s = |regM_i_ls_info[7:5];
    assign is_half_s  = regM_i_ls_info[1] | regM_i_ls_info[4] | regM_i_ls_info[6];
    assign is_word_s  = regM_i_ls_info[2] | regM_i_ls_info[7];
    assign to_hit_s   = TO_EN & (cnt_r == TO_LAST);

`ifdef MEM_MISALIGN_TRAP_EN
    assign trap_s = (is_half_s & regM_i_mem_addr[0]) |
                    (is_word_s & (regM_i_mem_addr[1:0] != 2'b00));
`else
    assign trap_s = 1'b0;
`endif

    // Byte offset rounded down to the access size's natural alignment.
    always_comb begin
        off_s = regM_i_mem_addr[1:0];
        if (is_word_s) begin
            off_s = 2'b00;
        end else if (is_half_s) begin
            off_s = {regM_i_mem_addr[1], 1'b0};
        end else begin
            off_s = regM_i_mem_addr[1:0];
        end
    end

    // Access sequencer: next state plus the one-cycle strobes for each transition.
    always_comb begin
        state_s     = state_r;
        enter_req_s = 1'b0;
        capture_s   = 1'b0;
        err_set_s   = 1'b0;
        mis_set_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (mem_op_s) begin
                    if (trap_s) begin
                        state_s   = ST_DONE;
                        mis_set_s = 1'b1;
                    end else begin
                        state_s     = ST_REQ;
                        enter_req_s = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                // Completion in this cycle takes precedence over the timeout.
                if (dmem.gnt && (we_r || dmem.rvalid)) begin
                    state_s   = ST_DONE;
                    capture_s = ~we_r;
                end else if (to_hit_s) begin
                    state_s   = ST_DONE;
                    err_set_s = 1'b1;
                end else if (dmem.gnt) begin
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (dmem.rvalid) begin
                    state_s   = ST_DONE;
                    capture_s = 1'b1;
                end else if (to_hit_s) begin
                    state_s   = ST_DONE;
                    err_set_s = 1'b1;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Bus command registers: loaded at launch, held until accepted or abandoned.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_r   <= 1'b0;
            we_r    <= 1'b0;
            wstrb_r <= 4'h0;
            addr_r  <= 32'h0000_0000;
            wdata_r <= 32'h0000_0000;
        end else if (enter_req_s) begin
            req_r   <= 1'b1;
            we_r    <= is_store_s;
            wstrb_r <= lane_strb(regM_i_ls_info, off_s);
            addr_r  <= {regM_i_mem_addr[31:2], 2'b00};
            wdata_r <= lane_wdata(regM_i_ls_info, regM_i_valB);
        end else if ((state_r == ST_REQ) && (state_s != ST_REQ)) begin
            req_r   <= 1'b0;
            we_r    <= 1'b0;
            wstrb_r <= 4'h0;
            addr_r  <= addr_r;
            wdata_r <= wdata_r;
        end else begin
            req_r   <= req_r;
            we_r    <= we_r;
            wstrb_r <= wstrb_r;
            addr_r  <= addr_r;
            wdata_r <= wdata_r;
        end
    end

    // Latch load kind and lane offset so formatting does not depend on late input changes.
    always_ff @(posedge clk) begin
        if (rst) begin
            ls_r  <= 5'b0_0000;
            off_r <= 2'b00;
        end else if ((state_r == ST_IDLE) && mem_op_s) begin
            ls_r  <= regM_i_ls_info[4:0];
            off_r <= off_s;
        end else begin
            ls_r  <= ls_r;
            off_r <= off_r;
        end
    end

    // Timeout counter: cleared at launch, counts every cycle spent in REQ or WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= 16'h0000;
        end else if (enter_req_s) begin
            cnt_r <= 16'h0000;
        end else if ((state_r == ST_REQ) || (state_r == ST_WAIT)) begin
            cnt_r <= cnt_r + 16'h0001;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Formatted load data, captured in the cycle rvalid is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            load_r <= 32'h0000_0000;
        end else if (capture_s) begin
            load_r <= load_format(ls_r, off_r, dmem.rdata);
        end else begin
            load_r <= load_r;
        end
    end

    // Completion flags: set only on the transition into DONE, so they are valid exactly there.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r <= 1'b0;
            mis_r <= 1'b0;
        end else begin
            err_r <= err_set_s;
            mis_r <= mis_set_s;
        end
    end

    // Upstream hold: asserted for a pending mem op and for the whole bus access.
    always_comb begin
        stall_s = 1'b0;
        case (state_r)
            ST_IDLE: stall_s = mem_op_s;
            ST_REQ:  stall_s = 1'b1;
            ST_WAIT: stall_s = 1'b1;
            ST_DONE: stall_s = 1'b0;
            default: stall_s = 1'b0;
        endcase
    end

    // Writeback value: load result in DONE, zero for a failed load or misalign, else valE.
    always_comb begin
        valm_s = regM_i_valE;
        if (state_r == ST_DONE) begin
            if (mis_r) begin
                valm_s = 32'h0000_0000;
            end else if (|ls_r) begin
                if (err_r) begin
                    valm_s = 32'h0000_0000;
                end else begin
                    valm_s = load_r;
                end
            end else begin
                valm_s = regM_i_valE;
            end
        end else begin
            valm_s = regM_i_valE;
        end
    end

    assign done_s = (state_r == ST_DONE);

    assign dmem.req   = req_r;
    assign dmem.we    = we_r;
    assign dmem.addr  = addr_r;
    assign dmem.wdata = wdata_r;
    assign dmem.wstrb = wstrb_r;

    assign memory_o_valM    = valm_s;
    assign memory_o_stall   = stall_s;
    assign memory_o_done    = done_s;
    assign memory_o_bus_err = done_s & err_r;
`ifdef MEM_MISALIGN_TRAP_EN
    assign memory_o_misalign = done_s & mis_r;
`else
    assign memory_o_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage
//   Randomized bench for memory_stage. Each operation has a bus response
//   timing (grant delay g, data delay r). A reference model computes the
//   following from the operation rules:
//   - the cycle on which the access completes,
//   - the bus command,
//   - the writeback value,
//   - the error flags.
module tb_memory_stage;

    localparam int TO = 4;

    localparam logic [7:0] OP_LB  = 8'h01;
    localparam logic [7:0] OP_LH  = 8'h02;
    localparam logic [7:0] OP_LW  = 8'h04;
    localparam logic [7:0] OP_LBU = 8'h08;
    localparam logic [7:0] OP_LHU = 8'h10;
    localparam logic [7:0] OP_SB  = 8'h20;
    localparam logic [7:0] OP_SH  = 8'h40;
    localparam logic [7:0] OP_SW  = 8'h80;

    logic        clk;
    logic        rst;
    logic        commit;
    logic [31:0] val_e;
    logic [31:0] mem_addr;
    logic [31:0] val_b;
    logic [7:0]  ls_info;
    logic [31:0] val_m;
    logic        stall;
    logic        done;
    logic        bus_err;
    logic        misalign;

    int checks   = 0;
    int failures = 0;

    memory_stage_if bus ();

    memory_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk               (clk),
        .rst               (rst),
        .regM_i_commit     (commit),
        .regM_i_valE       (val_e),
        .regM_i_mem_addr   (mem_addr),
        .regM_i_valB       (val_b),
        .regM_i_ls_info    (ls_info),
        .dmem              (bus),
        .memory_o_valM     (val_m),
        .memory_o_stall    (stall),
        .memory_o_done     (done),
        .memory_o_bus_err  (bus_err),
        .memory_o_misalign (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int op_size(input logic [7:0] ls);
        if (ls[2] || ls[7]) return 4;
        if (ls[1] || ls[4] || ls[6]) return 2;
        return 1;
    endfunction

    function automatic int eff_off(input logic [7:0] ls, input logic [31:0] a);
        int lo;
        int s;
        lo = int'(a[1:0]);
        s  = op_size(ls);
        return (lo / s) * s;
    endfunction

    function automatic bit is_misaligned(input logic [7:0] ls, input logic [31:0] a);
        int lo;
        lo = int'(a[1:0]);
        return (lo % op_size(ls)) != 0;
    endfunction

    function automatic logic [31:0] exp_load(input logic [7:0] ls, input logic [31:0] a,
                                             input logic [31:0] rd);
        int s;
        int off;
        logic [31:0] mask;
        logic [31:0] v;
        s   = op_size(ls);
        off = eff_off(ls, a);
        if (s == 4) mask = 32'hFFFF_FFFF;
        else        mask = (32'd1 << (8 * s)) - 32'd1;
        v = (rd >> (8 * off)) & mask;
        if ((ls[0] || ls[1]) && v[8 * s - 1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [3:0] exp_strb(input logic [7:0] ls, input logic [31:0] a);
        int t;
        if ((ls & 8'hE0) == 8'h00) return 4'h0;
        t = ((1 << op_size(ls)) - 1) << eff_off(ls, a);
        return t[3:0];
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [7:0] ls, input logic [31:0] b);
        if (op_size(ls) == 1) return 32'h0101_0101 * {24'h00_0000, b[7:0]};
        if (op_size(ls) == 2) return 32'h0001_0001 * {16'h0000, b[15:0]};
        return b;
    endfunction

    // One pipeline-register instruction: g = REQ cycles before gnt, r = cycles from gnt to rvalid.
    task automatic run_op(input logic c, input logic [7:0] ls, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] e,
                          input int g, input int r, input logic [31:0] rd);
        bit mem_op;
        bit ld;
        bit trap;
        bit tmo;
        bit gnt_ok;
        int need;
        int n_done;
        int req_last;
        int gnt_cyc;
        int rv_cyc;
        logic [31:0] exp_val;
        mem_op = c && (ls != 8'h00);
        ld     = (ls & 8'h1F) != 8'h00;
        trap   = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        trap   = mem_op && is_misaligned(ls, a);
`endif
        need     = ld ? (g + 1 + r) : (g + 1);
        tmo      = mem_op && !trap && (need > TO);
        gnt_ok   = mem_op && !trap && (g + 1 <= TO);
        gnt_cyc  = g + 2;
        rv_cyc   = g + 2 + r;
        n_done   = trap ? 2 : (tmo ? TO + 2 : need + 2);
        req_last = trap ? 0 : ((g + 1 <= TO) ? g + 2 : TO + 1);
        if (trap || (ld && tmo)) exp_val = 32'h0;
        else if (ld)             exp_val = exp_load(ls, a, rd);
        else                     exp_val = e;

        commit = c; ls_info = ls; mem_addr = a; val_b = b; val_e = e;
        if (!mem_op) begin
            bus.gnt = 1'b0; bus.rvalid = 1'b0;
            #1;
            check32("nomem_stall", 32'(stall), 32'd0);
            check32("nomem_done", 32'(done), 32'd0);
            check32("nomem_valm", val_m, e);
            @(negedge clk);
            return;
        end
        for (int cyc = 1; cyc <= n_done; cyc++) begin
            bus.gnt = gnt_ok && (cyc == gnt_cyc);
            if (ld && !tmo && !trap && (cyc == rv_cyc)) begin
                bus.rvalid = 1'b1; bus.rdata = rd;
            end else if (cyc >= 2 && cyc < gnt_cyc && cyc <= req_last) begin
                bus.rvalid = 1'($urandom_range(0, 1)); bus.rdata = $urandom();
            end else begin
                bus.rvalid = 1'b0; bus.rdata = $urandom();
            end
            #1;
            check32("stall", 32'(stall), 32'(cyc < n_done));
            check32("done", 32'(done), 32'(cyc == n_done));
            check32("req", 32'(bus.req), 32'((cyc >= 2) && (cyc <= req_last)));
            check32("valm", val_m, (cyc == n_done) ? exp_val : e);
            if (gnt_ok && (cyc == gnt_cyc)) begin
                check32("addr", bus.addr, a & 32'hFFFF_FFFC);
                check32("we", 32'(bus.we), 32'(!ld));
                check32("wstrb", 32'(bus.wstrb), 32'(exp_strb(ls, a)));
                if (!ld) check32("wdata", bus.wdata, exp_wdata(ls, b));
            end
            if (cyc == n_done) begin
                check32("bus_err", 32'(bus_err), 32'(tmo));
                check32("misalign", 32'(misalign), 32'(trap));
            end
            @(negedge clk);
        end
        bus.gnt = 1'b0; bus.rvalid = 1'b0;
    endtask

    logic [7:0] rls;
    int         rk;

    initial begin
        rst = 1'b1; commit = 1'b0; ls_info = 8'h00; mem_addr = 32'h0;
        val_b = 32'h0; val_e = 32'h0;
        bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.rdata = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        check32("rst_req", 32'(bus.req), 32'd0);
        check32("rst_we", 32'(bus.we), 32'd0);
        check32("rst_wstrb", 32'(bus.wstrb), 32'd0);
        check32("rst_done", 32'(done), 32'd0);
        check32("rst_stall", 32'(stall), 32'd0);
        check32("rst_err", 32'(bus_err), 32'd0);
        check32("rst_mis", 32'(misalign), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // directed cases
        run_op(1'b1, OP_SW,  32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 0, 0, 32'h0);
        run_op(1'b1, OP_LB,  32'h0000_0103, 32'h0, 32'h0, 0, 0, 32'h80FF_0000);
        run_op(1'b1, OP_LHU, 32'h0000_0202, 32'h0, 32'h0, 0, 2, 32'hBEEF_1234);
        run_op(1'b1, OP_SB,  32'h0000_0101, 32'h0000_00AB, 32'h0, 1, 0, 32'h0);
        run_op(1'b1, 8'h00,  32'h0, 32'h0, 32'h0000_0005, 0, 0, 32'h0);
        run_op(1'b1, OP_LW,  32'h0000_0400, 32'h0, 32'h0, 10, 0, 32'h0);
        run_op(1'b1, OP_SH,  32'h0000_0402, 32'h1234_5678, 32'h9, 3, 0, 32'h0);
        run_op(1'b1, OP_LH,  32'h0000_0406, 32'h0, 32'h9, 3, 1, 32'h8000_0000);
        run_op(1'b1, OP_LW,  32'h0000_0102, 32'h0, 32'h3, 0, 0, 32'h1234_5678);
        run_op(1'b0, OP_LW,  32'h0000_0100, 32'h0, 32'h0000_00EE, 0, 0, 32'h0);

        // reset while a store waits for grant: req drops on the next edge
        commit = 1'b1; ls_info = OP_SW; mem_addr = 32'h500; val_b = 32'h1; val_e = 32'h0;
        @(negedge clk);
        #1;
        check32("rreq_req_hi", 32'(bus.req), 32'd1);
        rst = 1'b1; commit = 1'b0; ls_info = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check32("rreq_req_lo", 32'(bus.req), 32'd0);
        check32("rreq_wstrb", 32'(bus.wstrb), 32'd0);
        check32("rreq_done", 32'(done), 32'd0);
        @(negedge clk);

        // reset while waiting for load data, then a late rvalid in IDLE
        commit = 1'b1; ls_info = OP_LW; mem_addr = 32'h300; val_e = 32'h77;
        @(negedge clk);
        bus.gnt = 1'b1;
        @(negedge clk);
        bus.gnt = 1'b0;
        #1;
        check32("rwait_stall", 32'(stall), 32'd1);
        rst = 1'b1; commit = 1'b0; ls_info = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check32("rwait_req", 32'(bus.req), 32'd0);
        check32("rwait_stall0", 32'(stall), 32'd0);
        check32("rwait_done", 32'(done), 32'd0);
        bus.rvalid = 1'b1; bus.rdata = 32'hCAFE_F00D;
        @(negedge clk);
        bus.rvalid = 1'b0;
        #1;
        check32("late_done", 32'(done), 32'd0);
        check32("late_valm", val_m, 32'h77);
        @(negedge clk);

`ifdef MEM_MISALIGN_TRAP_EN
        run_op(1'b1, OP_LW, 32'h0000_0102, 32'h0, 32'h5, 0, 0, 32'h0);
`endif

        // randomized operations
        for (int i = 0; i < 300; i++) begin
            rk = int'($urandom_range(0, 9));
            if (rk < 8) rls = 8'h01 << rk;
            else        rls = 8'h00;
            run_op(1'($urandom_range(0, 7) != 0), rls, $urandom(), $urandom(), $urandom(),
                   int'($urandom_range(0, 5)), int'($urandom_range(0, 3)), $urandom());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
